// File: rtl/fpu_add_subtract_function.sv
// Multi-cycle IEEE-754 single-precision add/subtract: one datapath step per FSM state,
// subnormals flushed to zero, result and flags registered on entry to DONE.
module fpu_add_subtract_function #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         beg_FSM,
  input  logic         rst_FSM,
  input  logic [W-1:0] Data_X,
  input  logic [W-1:0] Data_Y,
  input  logic         add_subt,
  input  logic [1:0]   r_mode,
  output logic         overflow_flag,
  output logic         underflow_flag,
  output logic         ready,
  output logic [W-1:0] final_result_ieee
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] LOAD      = 4'd1;
  localparam logic [3:0] COMPARE   = 4'd2;
  localparam logic [3:0] ALIGN     = 4'd3;
  localparam logic [3:0] ADD       = 4'd4;
  localparam logic [3:0] NORMALIZE = 4'd5;
  localparam logic [3:0] ROUND     = 4'd6;
  localparam logic [3:0] RENORM    = 4'd7;
  localparam logic [3:0] DONE      = 4'd8;

  logic [3:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic [W-1:0]      x_q, x_d, y_q, y_d;
  logic              sub_q, sub_d;
  logic [1:0]        mode_q, mode_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [7:0]        ea_q, ea_d, eb_q, eb_d;
  logic [23:0]       ma_q, ma_d, mb_q, mb_d;
  logic              special_q, special_d;
  logic [W-1:0]      special_res_q, special_res_d;
  logic              sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic [7:0]        el_q, el_d, diff_q, diff_d;
  logic [23:0]       ml_q, ml_d, ms_q, ms_d;
  logic [26:0]       al_q, al_d, as_q, as_d;
  logic [27:0]       sum_q, sum_d;
  logic [26:0]       norm_q, norm_d;
  logic signed [9:0] exp_q, exp_d;
  logic              zero_q, zero_d;
  logic [24:0]       rnd_q, rnd_d;
  logic [W-1:0]      result_q, result_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic              x_nan, x_inf, y_nan, y_inf, y_sign, b_big;
  logic [49:0]       shifted;
  logic [4:0]        lz;
  logic              inexact, round_up;
  logic              carry, use_max;
  logic [22:0]       mant;
  logic signed [9:0] e_fin;

  // rst_FSM wins over everything, including a start request in IDLE
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    if (rst_FSM) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (beg_FSM) state_d = LOAD;
        LOAD:      state_d = COMPARE;
        COMPARE:   state_d = ALIGN;
        ALIGN:     state_d = ADD;
        ADD:       state_d = NORMALIZE;
        NORMALIZE: state_d = ROUND;
        ROUND:     state_d = RENORM;
        RENORM:    state_d = DONE;
        DONE:      ready_d = 1'b1;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    sub_d  = sub_q;
    mode_d = mode_q;
    if (state_q == IDLE && beg_FSM && !rst_FSM) begin
      x_d    = Data_X;
      y_d    = Data_Y;
      sub_d  = add_subt;
      mode_d = r_mode;
    end
  end

  always_comb begin
    x_nan  = (&x_q[30:23]) & (|x_q[22:0]);
    x_inf  = (&x_q[30:23]) & ~(|x_q[22:0]);
    y_nan  = (&y_q[30:23]) & (|y_q[22:0]);
    y_inf  = (&y_q[30:23]) & ~(|y_q[22:0]);
    y_sign = y_q[31] ^ sub_q;
    sa_d = sa_q;
    sb_d = sb_q;
    ea_d = ea_q;
    eb_d = eb_q;
    ma_d = ma_q;
    mb_d = mb_q;
    special_d     = special_q;
    special_res_d = special_res_q;
    if (state_q == LOAD) begin
      sa_d = x_q[31];
      sb_d = y_sign;
      ea_d = x_q[30:23];
      eb_d = y_q[30:23];
      ma_d = (x_q[30:23] == 8'd0) ? 24'd0 : {1'b1, x_q[22:0]};
      mb_d = (y_q[30:23] == 8'd0) ? 24'd0 : {1'b1, y_q[22:0]};
      special_d = x_nan | y_nan | x_inf | y_inf;
      if (x_nan | y_nan | (x_inf & y_inf & (x_q[31] != y_sign)))
        special_res_d = 32'h7FC0_0000;
      else if (x_inf)
        special_res_d = {x_q[31], 8'hFF, 23'd0};
      else
        special_res_d = {y_sign, 8'hFF, 23'd0};
    end
  end

  always_comb begin
    b_big     = {eb_q, mb_q} > {ea_q, ma_q};
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    el_d      = el_q;
    diff_d    = diff_q;
    ml_d      = ml_q;
    ms_d      = ms_q;
    if (state_q == COMPARE) begin
      sign_d    = b_big ? sb_q : sa_q;
      eff_sub_d = sa_q ^ sb_q;
      el_d      = b_big ? eb_q : ea_q;
      diff_d    = b_big ? (eb_q - ea_q) : (ea_q - eb_q);
      ml_d      = b_big ? mb_q : ma_q;
      ms_d      = b_big ? ma_q : mb_q;
    end
  end

  // Beyond 25 positions the whole smaller significand collapses into sticky
  always_comb begin
    shifted = {ms_q, 26'd0} >> diff_q;
    al_d    = al_q;
    as_d    = as_q;
    sum_d   = sum_q;
    if (state_q == ALIGN) begin
      al_d = {ml_q, 3'b000};
      as_d = (diff_q >= 8'd26) ? {26'd0, |ms_q} : {shifted[49:24], |shifted[23:0]};
    end
    if (state_q == ADD)
      sum_d = eff_sub_q ? ({1'b0, al_q} - {1'b0, as_q}) : ({1'b0, al_q} + {1'b0, as_q});
  end

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++)
      if (sum_q[i]) lz = 5'(26 - i);
    norm_d = norm_q;
    exp_d  = exp_q;
    zero_d = zero_q;
    if (state_q == NORMALIZE) begin
      zero_d = (sum_q == 28'd0);
      if (sum_q[27]) begin
        norm_d = {sum_q[27:2], |sum_q[1:0]};
        exp_d  = $signed({2'b00, el_q}) + 10'sd1;
      end else begin
        norm_d = sum_q[26:0] << lz;
        exp_d  = $signed({2'b00, el_q}) - $signed({5'd0, lz});
      end
    end
  end

  always_comb begin
    inexact = |norm_q[2:0];
    case (mode_q)
      2'b00:   round_up = 1'b0;
      2'b01:   round_up = sign_q & inexact;
      2'b10:   round_up = ~sign_q & inexact;
      default: round_up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    endcase
    rnd_d = rnd_q;
    if (state_q == ROUND)
      rnd_d = {1'b0, norm_q[26:3]} + {24'd0, round_up};
  end

  // Rounding carry-out renormalizes to 1.0 with the exponent bumped
  always_comb begin
    carry   = rnd_q[24];
    mant    = carry ? rnd_q[23:1] : rnd_q[22:0];
    e_fin   = carry ? (exp_q + 10'sd1) : exp_q;
    use_max = (mode_q == 2'b00) | ((mode_q == 2'b01) & ~sign_q) | ((mode_q == 2'b10) & sign_q);
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (state_q == RENORM && !rst_FSM) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
      if (special_q) begin
        result_d = special_res_q;
      end else if (zero_q) begin
        if (eff_sub_q) result_d = (mode_q == 2'b01) ? 32'h8000_0000 : 32'h0000_0000;
        else           result_d = {sign_q, 31'd0};
      end else if (e_fin >= 10'sd255) begin
        ovf_d    = 1'b1;
        result_d = use_max ? {sign_q, 8'hFE, 23'h7F_FFFF} : {sign_q, 8'hFF, 23'd0};
      end else if (e_fin <= 10'sd0) begin
        unf_d    = 1'b1;
        result_d = {sign_q, 31'd0};
      end else begin
        result_d = {sign_q, e_fin[7:0], mant};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      ready_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      sub_q         <= 1'b0;
      mode_q        <= 2'b00;
      sa_q          <= 1'b0;
      sb_q          <= 1'b0;
      ea_q          <= 8'd0;
      eb_q          <= 8'd0;
      ma_q          <= 24'd0;
      mb_q          <= 24'd0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      sign_q        <= 1'b0;
      eff_sub_q     <= 1'b0;
      el_q          <= 8'd0;
      diff_q        <= 8'd0;
      ml_q          <= 24'd0;
      ms_q          <= 24'd0;
      al_q          <= 27'd0;
      as_q          <= 27'd0;
      sum_q         <= 28'd0;
      norm_q        <= 27'd0;
      exp_q         <= 10'sd0;
      zero_q        <= 1'b0;
      rnd_q         <= 25'd0;
      result_q      <= '0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      x_q           <= x_d;
      y_q           <= y_d;
      sub_q         <= sub_d;
      mode_q        <= mode_d;
      sa_q          <= sa_d;
      sb_q          <= sb_d;
      ea_q          <= ea_d;
      eb_q          <= eb_d;
      ma_q          <= ma_d;
      mb_q          <= mb_d;
      special_q     <= special_d;
      special_res_q <= special_res_d;
      sign_q        <= sign_d;
      eff_sub_q     <= eff_sub_d;
      el_q          <= el_d;
      diff_q        <= diff_d;
      ml_q          <= ml_d;
      ms_q          <= ms_d;
      al_q          <= al_d;
      as_q          <= as_d;
      sum_q         <= sum_d;
      norm_q        <= norm_d;
      exp_q         <= exp_d;
      zero_q        <= zero_d;
      rnd_q         <= rnd_d;
      result_q      <= result_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
    end
  end

  assign ready             = ready_q;
  assign final_result_ieee = result_q;
  assign overflow_flag     = ovf_q;
  assign underflow_flag    = unf_q;

endmodule

// File: tb/tb_fpu_add_subtract_function.sv
// Bench for fpu_add_subtract_function: directed corners plus random operands checked
// against an exact-integer reference model of the add/subtract and rounding rules.
module tb_fpu_add_subtract_function;

  logic        clk = 1'b0;
  logic        rst;
  logic        beg_FSM;
  logic        rst_FSM;
  logic [31:0] Data_X;
  logic [31:0] Data_Y;
  logic        add_subt;
  logic [1:0]  r_mode;
  logic        overflow_flag;
  logic        underflow_flag;
  logic        ready;
  logic [31:0] final_result_ieee;

  int checks = 0;
  int errors = 0;

  fpu_add_subtract_function #(.W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .beg_FSM           (beg_FSM),
    .rst_FSM           (rst_FSM),
    .Data_X            (Data_X),
    .Data_Y            (Data_Y),
    .add_subt          (add_subt),
    .r_mode            (r_mode),
    .overflow_flag     (overflow_flag),
    .underflow_flag    (underflow_flag),
    .ready             (ready),
    .final_result_ieee (final_result_ieee)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, actual, expected);
    end
  endtask

  // Exact sum as a wide integer, then generic round-to-24-bits; returns {ovf, unf, result}
  function automatic logic [33:0] refModel(input logic [31:0] x, input logic [31:0] y,
                                           input logic op, input logic [1:0] mode);
    logic         sx, sy, sl, x_nan, y_nan, x_inf, y_inf, eff_sub, inexact, up, use_max;
    int           ex, ey, el, es, d, shamt, p, big_e;
    logic [23:0]  mx, my, ml, ms;
    logic [127:0] big, q, rem, half;
    sx = x[31];
    sy = y[31] ^ op;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    x_nan = (ex == 255) && (x[22:0] != 0);
    y_nan = (ey == 255) && (y[22:0] != 0);
    x_inf = (ex == 255) && (x[22:0] == 0);
    y_inf = (ey == 255) && (y[22:0] == 0);
    if (x_nan || y_nan || (x_inf && y_inf && sx != sy)) return {2'b00, 32'h7FC0_0000};
    if (x_inf) return {2'b00, sx, 8'hFF, 23'd0};
    if (y_inf) return {2'b00, sy, 8'hFF, 23'd0};
    mx = (ex == 0) ? 24'd0 : {1'b1, x[22:0]};
    my = (ey == 0) ? 24'd0 : {1'b1, y[22:0]};
    if (ey > ex || (ey == ex && my > mx)) begin
      sl = sy; el = ey; ml = my; es = ex; ms = mx;
    end else begin
      sl = sx; el = ex; ml = mx; es = ey; ms = my;
    end
    eff_sub = (sx != sy);
    d = el - es;
    shamt = (d > 62) ? 62 : d;
    big = 128'(ml) << shamt;
    if (eff_sub) big = big - 128'(ms);
    else         big = big + 128'(ms);
    if (big == 0) begin
      if (eff_sub) return {2'b00, (mode == 2'b01) ? 32'h8000_0000 : 32'h0000_0000};
      return {2'b00, sl, 31'd0};
    end
    p = 0;
    for (int i = 0; i < 128; i++) if (big[i]) p = i;
    if (p > 23) begin
      q    = big >> (p - 23);
      rem  = big & ((128'd1 << (p - 23)) - 128'd1);
      half = 128'd1 << (p - 24);
    end else begin
      q    = big << (23 - p);
      rem  = 128'd0;
      half = 128'd0;
    end
    big_e = el - shamt + (p - 23);
    inexact = (rem != 0);
    case (mode)
      2'b00:   up = 1'b0;
      2'b01:   up = sl && inexact;
      2'b10:   up = !sl && inexact;
      default: up = (rem > half) || (inexact && rem == half && q[0]);
    endcase
    q = q + 128'(up);
    if (q[24]) begin
      q = q >> 1;
      big_e++;
    end
    if (big_e >= 255) begin
      use_max = (mode == 2'b00) || (mode == 2'b01 && !sl) || (mode == 2'b10 && sl);
      return {2'b10, use_max ? {sl, 8'hFE, 23'h7F_FFFF} : {sl, 8'hFF, 23'd0}};
    end
    if (big_e <= 0) return {2'b01, sl, 31'd0};
    return {2'b00, sl, 8'(big_e), q[22:0]};
  endfunction

  function automatic logic [31:0] randOperand();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 15))
      0: v[30:23] = 8'd0;
      1: begin
        v[30:23] = 8'hFF;
        if (v[0]) v[22:0] = 23'd0;
      end
      2:       v[30:23] = 8'hFE - 8'($urandom_range(0, 2));
      3:       v[30:23] = 8'($urandom_range(1, 3));
      default: v[30:23] = 8'($urandom_range(100, 150));
    endcase
    return v;
  endfunction

  // One transaction: fixed-latency ready check, result/flags, then rst_FSM hold check
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic op,
                               input logic [1:0] mode, input logic [33:0] expv, input string tag);
    @(negedge clk);
    Data_X = x; Data_Y = y; add_subt = op; r_mode = mode; beg_FSM = 1'b1;
    @(posedge clk);
    #1;
    beg_FSM  = 1'b0;
    Data_X   = $urandom;
    Data_Y   = $urandom;
    add_subt = 1'($urandom);
    r_mode   = 2'($urandom);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      beg_FSM = (i == 2);
    end
    checkOutput({tag, " ready_early"}, {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, " ready"}, {31'd0, ready}, 32'd1);
    checkOutput({tag, " result"}, final_result_ieee, expv[31:0]);
    checkOutput({tag, " overflow"}, {31'd0, overflow_flag}, {31'd0, expv[33]});
    checkOutput({tag, " underflow"}, {31'd0, underflow_flag}, {31'd0, expv[32]});
    rst_FSM = 1'b1;
    @(posedge clk);
    #1;
    rst_FSM = 1'b0;
    checkOutput({tag, " ready_clear"}, {31'd0, ready}, 32'd0);
    checkOutput({tag, " result_hold"}, final_result_ieee, expv[31:0]);
  endtask

  initial begin
    logic [31:0] x, y;
    logic        op;
    logic [1:0]  mode;
    logic        saw_ready;

    rst = 1'b1; beg_FSM = 1'b0; rst_FSM = 1'b0;
    Data_X = 32'd0; Data_Y = 32'd0; add_subt = 1'b0; r_mode = 2'b00;
    #3 rst = 1'b0;
    #4;
    checkOutput("reset ready", {31'd0, ready}, 32'd0);
    checkOutput("reset result", final_result_ieee, 32'd0);
    checkOutput("reset flags", {30'd0, overflow_flag, underflow_flag}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(32'h3F80_0000, 32'h4000_0000, 1'b0, 2'b11, {2'b00, 32'h4040_0000}, "one_plus_two");

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    Data_X = 32'h4040_0000; Data_Y = 32'h3F80_0000; add_subt = 1'b0; r_mode = 2'b11; beg_FSM = 1'b1;
    @(posedge clk);
    #1 beg_FSM = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async ready", {31'd0, ready}, 32'd0);
    checkOutput("async result", final_result_ieee, 32'd0);
    checkOutput("async flags", {30'd0, overflow_flag, underflow_flag}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    saw_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (ready) saw_ready = 1'b1;
    end
    checkOutput("no_ready_after_reset", {31'd0, saw_ready}, 32'd0);

    applyStimulus(32'h3F80_0000, 32'h3F80_0000, 1'b1, 2'b11, {2'b00, 32'h0000_0000}, "cancel_rne");
    applyStimulus(32'h3F80_0000, 32'h3F80_0000, 1'b1, 2'b01, {2'b00, 32'h8000_0000}, "cancel_rdn");
    applyStimulus(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 2'b11, {2'b10, 32'h7F80_0000}, "ovf_rne");
    applyStimulus(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 2'b00, {2'b10, 32'h7F7F_FFFF}, "ovf_rz");
    applyStimulus(32'hFF7F_FFFF, 32'hFF7F_FFFF, 1'b0, 2'b10, {2'b10, 32'hFF7F_FFFF}, "ovf_neg_rup");
    applyStimulus(32'hFF7F_FFFF, 32'hFF7F_FFFF, 1'b0, 2'b01, {2'b10, 32'hFF80_0000}, "ovf_neg_rdn");
    applyStimulus(32'h3F80_0000, 32'h3380_0000, 1'b0, 2'b11, {2'b00, 32'h3F80_0000}, "tie_rne");
    applyStimulus(32'h3F80_0000, 32'h3380_0000, 1'b0, 2'b10, {2'b00, 32'h3F80_0001}, "tie_rup");
    applyStimulus(32'h3F80_0000, 32'h3380_0000, 1'b0, 2'b00, {2'b00, 32'h3F80_0000}, "tie_rz");
    applyStimulus(32'h0080_0001, 32'h0080_0000, 1'b1, 2'b11, {2'b01, 32'h0000_0000}, "underflow");
    applyStimulus(32'h7F80_0000, 32'h7F80_0000, 1'b1, 2'b11, {2'b00, 32'h7FC0_0000}, "inf_minus_inf");
    applyStimulus(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 2'b11, {2'b00, 32'h7FC0_0000}, "nan_in");
    applyStimulus(32'hFF80_0000, 32'h3F80_0000, 1'b0, 2'b11, {2'b00, 32'hFF80_0000}, "neg_inf");

    for (int n = 0; n < 300; n++) begin
      x = randOperand();
      y = randOperand();
      case ($urandom_range(0, 3))
        0: y = {y[31], x[30:0] ^ {27'd0, 4'($urandom)}};
        1: if (x[30:23] > 8'd3 && x[30:23] < 8'd255) y[30:23] = x[30:23] - 8'($urandom_range(0, 3));
        default: ;
      endcase
      op   = 1'($urandom);
      mode = 2'($urandom);
      applyStimulus(x, y, op, mode, refModel(x, y, op, mode), $sformatf("rnd%0d %08h %08h op%0d m%0d", n, x, y, op, mode));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
